regfile_sb: RTL and testbench
=============================

REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 SHALL have parameter WIDTH, 64, data bits per register.
REQ-002 SHALL have parameter NREGS, 32, register count (power of two, >=4); AW = clog2(NREGS).
REQ-003 SHALL have parameter NREAD, 2, read port count.
REQ-004 SHALL have parameter NWRITE, 2, write port count.
REQ-005 SHALL have port clk  in  1  sole clock, rising edge.
REQ-006 SHALL have port rstn  in  1  asynchronous active-low reset.
REQ-007 SHALL have port ready_o  out  1  high once init sweep is complete.
REQ-008 SHALL have port we_i  in  NWRITE  per-port write enable.
REQ-009 SHALL have port waddr_i  in  NWRITE x AW  write addresses.
REQ-010 SHALL have port wdata_i  in  NWRITE x WIDTH  write data.
REQ-011 SHALL have port raddr_i  in  NREAD x AW  read addresses.
REQ-012 SHALL have port rdata_o  out  NREAD x WIDTH  read data.
REQ-013 SHALL have port rbusy_o  out  NREAD  scoreboard busy for the read address.
REQ-014 SHALL have port alloc_i  in  1  mark alloc_addr_i busy (producer issued).
REQ-015 SHALL have port alloc_addr_i  in  AW  register being allocated.
REQ-016 SHALL have port flush_i  in  1  clear all busy bits.
REQ-017 SHALL have port conflict_o  out  1  sticky: two write ports hit the same nonzero address in one cycle.

Function
REQ-018 SHALL implement FSM INIT -> READY; INIT entered on reset; sweep counter clears one register (data=0, busy=0) per cycle, index 0..NREGS-1; after the NREGS-1 clear, state=READY, ready_o=1 next cycle.
REQ-019 SHALL ignore we_i, alloc_i, flush_i while INIT; rdata_o=0, rbusy_o=0 while INIT.
REQ-020 SHALL never write, allocate or mark busy register 0; reads of 0 return 0, rbusy 0.
REQ-021 SHALL write wdata_i[w] to waddr_i[w] at the clock edge when we_i[w]=1, READY, address nonzero.
REQ-022 SHALL resolve same-address writes in one cycle by highest port index winning, and set conflict_o the following cycle.
REQ-023 SHALL return rdata_o[r] = array value, overridden by in-flight write data to the same nonzero address (highest port index wins) in the same cycle.
REQ-024 SHALL set busy[alloc_addr_i] at the edge when alloc_i=1; any write to an address clears its busy bit at the edge.
REQ-025 SHALL give alloc priority over a same-cycle write to the same address: data written, busy remains 1.
REQ-026 SHALL clear all busy bits at the edge when flush_i=1; flush overrides same-cycle alloc_i; same-cycle writes still update data.
REQ-027 SHALL drive rbusy_o[r] = busy[raddr_i[r]] AND NOT (same-cycle write to that address), ignoring same-cycle alloc.

Reset
REQ-028 SHALL on rstn=0 immediately force state=INIT, sweep counter=0, ready_o=0, conflict_o=0, all busy=0, registered read outputs=0; data array is not reset (cleared by sweep).
REQ-029 SHALL restart the full sweep if rstn asserts mid-sweep or mid-operation.

Configuration
REQ-030 SHALL, with REGFILE_SB_RDREG_EN defined, register rdata_o and rbusy_o: values computed per REQ-023/027 from cycle-t inputs appear at cycle t+1 (one-cycle latency, bypass included).
REQ-031 SHALL, without REGFILE_SB_RDREG_EN, produce rdata_o and rbusy_o combinationally (zero latency).

Verification
REQ-032 SHALL cover reset release -> ready_o=0 for exactly 32 cycles, then 1; all reads 0, rbusy 0.
REQ-033 SHALL cover write x5=0xDEAD on port0 while reading x5 -> rdata=0xDEAD same cycle (combinational build) or next cycle (RDREG build).
REQ-034 SHALL cover port0 x7=0x1, port1 x7=0x2 same cycle -> x7 reads 0x2, conflict_o=1 next cycle and stays 1 until reset.
REQ-035 SHALL cover alloc x9, then write x9=0x33 two cycles later -> rbusy=1 between, 0 from the write cycle; alloc+write x9 same cycle -> busy stays 1, data 0x33.
REQ-036 SHALL cover alloc x3, x4, then flush with concurrent alloc x6 -> all busy 0 next cycle, including x6.
REQ-037 SHALL cover rstn pulse at sweep index 10 -> sweep restarts, ready_o high only after 32 further cycles.

Source files
------------

// File: rtl/regfile_sb.sv
// regfile_sb: multi-port register file with a busy scoreboard and a power-up clear sweep.
// Build option REGFILE_SB_RDREG_EN registers rdata_o/rbusy_o (one-cycle read latency).
module regfile_sb #(
  parameter int unsigned WIDTH  = 64,
  parameter int unsigned NREGS  = 32,
  parameter int unsigned NREAD  = 2,
  parameter int unsigned NWRITE = 2,
  localparam int unsigned AW    = $clog2(NREGS)
) (
  input  logic                          clk,
  input  logic                          rstn,
  output logic                          ready_o,
  input  logic [NWRITE-1:0]             we_i,
  input  logic [NWRITE-1:0][AW-1:0]     waddr_i,
  input  logic [NWRITE-1:0][WIDTH-1:0]  wdata_i,
  input  logic [NREAD-1:0][AW-1:0]      raddr_i,
  output logic [NREAD-1:0][WIDTH-1:0]   rdata_o,
  output logic [NREAD-1:0]              rbusy_o,
  input  logic                          alloc_i,
  input  logic [AW-1:0]                 alloc_addr_i,
  input  logic                          flush_i,
  output logic                          conflict_o
);

  localparam logic [0:0]    ST_INIT  = 1'b0;
  localparam logic [0:0]    ST_READY = 1'b1;
  localparam logic [AW-1:0] LAST_IDX = AW'(NREGS - 1);

  logic [0:0]                   state;
  logic [0:0]                   state_nxt;
  logic [AW-1:0]                sweep_cnt;
  logic                         ready;
  logic [WIDTH-1:0]             mem [NREGS];
  logic [NREGS-1:0]             busy;
  logic [NREGS-1:0]             busy_nxt;
  logic [NWRITE-1:0]            wr_en;
  logic [NREGS-1:0]             wr_hit;
  logic                         conflict_c;
  logic [NREAD-1:0][WIDTH-1:0]  rdata_c;
  logic [NREAD-1:0]             rbusy_c;

  // State register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= ST_INIT;
    else       state <= state_nxt;
  end

  // Next-state: leave INIT once the last register has been cleared
  always_comb begin
    state_nxt = state;
    case (state)
      ST_INIT:  if (sweep_cnt == LAST_IDX) state_nxt = ST_READY;
      ST_READY: state_nxt = ST_READY;
      default:  state_nxt = ST_INIT;
    endcase
  end

  assign ready   = (state == ST_READY);
  assign ready_o = ready;

  // Clear-sweep index, one register per cycle while in INIT
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                sweep_cnt <= '0;
    else if (state == ST_INIT) sweep_cnt <= sweep_cnt + AW'(1);
  end

  // Qualified write enables and per-register write hit map
  always_comb begin
    wr_en  = '0;
    wr_hit = '0;
    for (int w = 0; w < NWRITE; w++) begin
      wr_en[w] = ready && we_i[w] && (waddr_i[w] != '0);
      if (wr_en[w]) wr_hit[waddr_i[w]] = 1'b1;
    end
  end

  // Any pair of live write ports aimed at the same register
  always_comb begin
    conflict_c = 1'b0;
    for (int a = 0; a < NWRITE; a++) begin
      for (int b = a + 1; b < NWRITE; b++) begin
        if (wr_en[a] && wr_en[b] && (waddr_i[a] == waddr_i[b])) conflict_c = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)          conflict_o <= 1'b0;
    else if (conflict_c) conflict_o <= 1'b1;
  end

  // Busy update priority: flush > alloc > write-clear; register 0 is never busy
  always_comb begin
    busy_nxt = busy & ~wr_hit;
    if (alloc_i && (alloc_addr_i != '0)) busy_nxt[alloc_addr_i] = 1'b1;
    if (flush_i) busy_nxt = '0;
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)      busy <= '0;
    else if (ready) busy <= busy_nxt;
    else            busy[sweep_cnt] <= 1'b0;
  end

  // Data array has no reset; the sweep zeroes it, later ports overwrite earlier ones
  always_ff @(posedge clk) begin
    if (!ready) begin
      mem[sweep_cnt] <= '0;
    end else begin
      for (int w = 0; w < NWRITE; w++) begin
        if (wr_en[w]) mem[waddr_i[w]] <= wdata_i[w];
      end
    end
  end

  // Read path with same-cycle write bypass
  always_comb begin
    rdata_c = '0;
    rbusy_c = '0;
    for (int r = 0; r < NREAD; r++) begin
      if (ready && (raddr_i[r] != '0)) begin
        rdata_c[r] = mem[raddr_i[r]];
        for (int w = 0; w < NWRITE; w++) begin
          if (wr_en[w] && (waddr_i[w] == raddr_i[r])) rdata_c[r] = wdata_i[w];
        end
        rbusy_c[r] = busy[raddr_i[r]] && !wr_hit[raddr_i[r]];
      end
    end
  end

`ifdef REGFILE_SB_RDREG_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rdata_o <= '0;
      rbusy_o <= '0;
    end else begin
      rdata_o <= rdata_c;
      rbusy_o <= rbusy_c;
    end
  end
`else
  assign rdata_o = rdata_c;
  assign rbusy_o = rbusy_c;
`endif

endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: directed + random stimulus for regfile_sb, checked against an array-level model.
module tb_regfile_sb;

  localparam int unsigned W  = 64;
  localparam int unsigned N  = 32;
  localparam int unsigned AW = 5;

  logic                clk = 1'b0;
  logic                rstn = 1'b0;
  logic                ready;
  logic [1:0]          we;
  logic [1:0][AW-1:0]  waddr;
  logic [1:0][W-1:0]   wdata;
  logic [1:0][AW-1:0]  raddr;
  logic [1:0][W-1:0]   rdata;
  logic [1:0]          rbusy;
  logic                alloc;
  logic [AW-1:0]       alloc_addr;
  logic                flush;
  logic                conflict;

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;

  logic [W-1:0] m_mem [N];
  bit           m_busy [N];
  bit           m_conf;
  int           m_cnt;
  logic [W-1:0] exp_d [2];
  logic         exp_b [2];

  regfile_sb dut (
    .clk          (clk),
    .rstn         (rstn),
    .ready_o      (ready),
    .we_i         (we),
    .waddr_i      (waddr),
    .wdata_i      (wdata),
    .raddr_i      (raddr),
    .rdata_o      (rdata),
    .rbusy_o      (rbusy),
    .alloc_i      (alloc),
    .alloc_addr_i (alloc_addr),
    .flush_i      (flush),
    .conflict_o   (conflict)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_mem[i]  = '0;
      m_busy[i] = 1'b0;
    end
    m_conf = 1'b0;
    m_cnt  = 0;
  endtask

  // Expected read results for the inputs currently applied
  task automatic model_expect();
    for (int r = 0; r < 2; r++) begin
      int  a;
      bit  hit;
      a        = int'(raddr[r]);
      hit      = 1'b0;
      exp_d[r] = '0;
      exp_b[r] = 1'b0;
      if (m_cnt >= N && a != 0) begin
        exp_d[r] = m_mem[a];
        for (int w = 0; w < 2; w++) begin
          if (we[w] && int'(waddr[w]) == a) begin
            exp_d[r] = wdata[w];
            hit      = 1'b1;
          end
        end
        exp_b[r] = m_busy[a] && !hit;
      end
    end
  endtask

  // Architectural effect of one clock edge
  task automatic model_update();
    if (m_cnt < N) begin
      m_cnt++;
      return;
    end
    if (we == 2'b11 && waddr[0] == waddr[1] && waddr[0] != '0) m_conf = 1'b1;
    for (int w = 0; w < 2; w++) begin
      if (we[w] && waddr[w] != '0) begin
        m_mem[waddr[w]]  = wdata[w];
        m_busy[waddr[w]] = 1'b0;
      end
    end
    if (alloc && alloc_addr != '0) m_busy[alloc_addr] = 1'b1;
    if (flush) for (int i = 0; i < N; i++) m_busy[i] = 1'b0;
  endtask

  task automatic check_reads();
    for (int r = 0; r < 2; r++) begin
      chk($sformatf("rdata%0d_a%0d", r, raddr[r]), rdata[r], exp_d[r]);
      chk($sformatf("rbusy%0d_a%0d", r, raddr[r]), W'(rbusy[r]), W'(exp_b[r]));
    end
  endtask

  task automatic check_status();
    chk("ready", W'(ready), W'(m_cnt >= N));
    chk("conflict", W'(conflict), W'(m_conf));
  endtask

  // One clock cycle with the inputs already driven; called at a negedge
  task automatic step();
    model_expect();
`ifndef REGFILE_SB_RDREG_EN
    #1;
    check_reads();
`endif
    @(posedge clk);
    model_update();
    #1;
`ifdef REGFILE_SB_RDREG_EN
    check_reads();
`endif
    check_status();
    @(negedge clk);
  endtask

  task automatic idle();
    we         = '0;
    waddr      = '0;
    wdata      = '0;
    raddr      = '0;
    alloc      = 1'b0;
    alloc_addr = '0;
    flush      = 1'b0;
  endtask

  function automatic logic [AW-1:0] rnd_addr();
    if ($urandom_range(0, 3) == 0) return AW'($urandom);
    return AW'($urandom_range(0, 7));
  endfunction

  task automatic rand_in();
    we         = 2'($urandom);
    waddr[0]   = rnd_addr();
    waddr[1]   = rnd_addr();
    wdata[0]   = {$urandom, $urandom};
    wdata[1]   = {$urandom, $urandom};
    raddr[0]   = rnd_addr();
    raddr[1]   = rnd_addr();
    alloc      = ($urandom_range(0, 2) == 0);
    alloc_addr = rnd_addr();
    flush      = ($urandom_range(0, 15) == 0);
  endtask

  // Asynchronous reset pulse spanning one rising edge; called at a negedge
  task automatic do_reset();
    idle();
    rstn = 1'b0;
    #1;
    model_reset();
    model_expect();
    check_reads();
    check_status();
    @(negedge clk);
    rstn = 1'b1;
  endtask

  initial begin
    idle();
    @(negedge clk);
    do_reset();

    // Sweep: inputs are random and must be ignored, ready rises after 32 edges
    for (int i = 0; i < 32; i++) begin
      rand_in();
      step();
    end

    // Write x5 while reading it: bypass
    idle(); we = 2'b01; waddr[0] = 5'd5; wdata[0] = 64'hDEAD; raddr[0] = 5'd5; step();
    idle(); raddr[0] = 5'd5; raddr[1] = 5'd0; step();

    // Both ports write x7: port 1 wins, sticky conflict
    idle(); we = 2'b11; waddr[0] = 5'd7; waddr[1] = 5'd7; wdata[0] = 64'h1; wdata[1] = 64'h2;
    raddr[0] = 5'd7; step();
    idle(); raddr[0] = 5'd7; raddr[1] = 5'd7; step();
    idle(); repeat (3) step();

    // Alloc x9, write two cycles later
    idle(); alloc = 1'b1; alloc_addr = 5'd9; raddr[0] = 5'd9; step();
    idle(); raddr[0] = 5'd9; step();
    idle(); we = 2'b01; waddr[0] = 5'd9; wdata[0] = 64'h33; raddr[0] = 5'd9; step();
    idle(); raddr[0] = 5'd9; step();
    // Alloc and write x9 together: busy stays set, data lands
    idle(); alloc = 1'b1; alloc_addr = 5'd9; we = 2'b10; waddr[1] = 5'd9; wdata[1] = 64'h33;
    raddr[1] = 5'd9; step();
    idle(); raddr[0] = 5'd9; raddr[1] = 5'd9; step();

    // Alloc x3, x4, then flush with a concurrent alloc x6
    idle(); alloc = 1'b1; alloc_addr = 5'd3; step();
    idle(); alloc = 1'b1; alloc_addr = 5'd4; step();
    idle(); raddr[0] = 5'd3; raddr[1] = 5'd4; step();
    idle(); flush = 1'b1; alloc = 1'b1; alloc_addr = 5'd6; raddr[0] = 5'd3; raddr[1] = 5'd4; step();
    idle(); raddr[0] = 5'd3; raddr[1] = 5'd6; step();
    idle(); raddr[0] = 5'd4; raddr[1] = 5'd9; step();

    // Register 0 is never written or allocated
    idle(); we = 2'b11; waddr[0] = 5'd0; waddr[1] = 5'd0; wdata[0] = '1; wdata[1] = '1;
    alloc = 1'b1; alloc_addr = 5'd0; raddr[0] = 5'd0; step();
    idle(); raddr[0] = 5'd0; step();

    // Reset mid-operation clears conflict and restarts the sweep
    do_reset();
    for (int i = 0; i < 10; i++) begin
      rand_in();
      step();
    end
    // Reset again at sweep index 10
    do_reset();
    for (int i = 0; i < 32; i++) begin
      rand_in();
      step();
    end

    for (int i = 0; i < 400; i++) begin
      rand_in();
      step();
    end

    do_reset();
    for (int i = 0; i < 40; i++) begin
      rand_in();
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
